// File: rtl/ntt_pkg.sv
// ============================================================================
// Module : ntt_pkg
// Brief  : Shared NTT frame constants and the 3-bit index reversal helper.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ntt_pkg;

    localparam int COEF_W     = 8;
    localparam int FRAME_N    = 8;
    localparam int FRAME_LOG2 = 3;

    function automatic logic [FRAME_LOG2-1:0] bitrev3(input logic [FRAME_LOG2-1:0] k);
        return {k[0], k[1], k[2]};
    endfunction

endpackage

`default_nettype wire

// File: rtl/vec_bit_reversal.sv
// ============================================================================
// Module : vec_bit_reversal
// Brief  : Pure-wiring permutation of 8 lanes into bit-reversed lane order.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vec_bit_reversal
    import ntt_pkg::*;
#(
    parameter int WIDTH = COEF_W
) (
    input  logic [WIDTH*FRAME_N-1:0] vec_in,
    output logic [WIDTH*FRAME_N-1:0] vec_out
);

    // Lane k takes source lane bitrev3(k); the source index is elaborated per lane.
    for (genvar k = 0; k < FRAME_N; k++) begin : g_lane
        localparam int SRC = ((k & 1) << 2) | (k & 2) | ((k >> 2) & 1);
        assign vec_out[k*WIDTH +: WIDTH] = vec_in[SRC*WIDTH +: WIDTH];
    end

endmodule

`default_nettype wire

// File: rtl/bitrev_stream_ctrl.sv
// ============================================================================
// Module : bitrev_stream_ctrl
// Brief  : Ping-pong frame buffer streaming 8-coefficient frames out in
//          bit-reversed order at one beat per cycle.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bitrev_stream_ctrl
    import ntt_pkg::*;
#(
    parameter int WIDTH = COEF_W,
    parameter int N     = FRAME_N
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic [15:0]      frames_done
);

    localparam int LOG2N = FRAME_LOG2;

    logic [WIDTH-1:0]   r_bank [2][N];
    logic [1:0]         r_bank_full;
    logic               r_wr_bank;
    logic [LOG2N-1:0]   r_wr_idx;
    logic               r_rd_bank;
    logic [LOG2N-1:0]   r_rd_idx;
    logic [15:0]        r_frames_done;

    logic [WIDTH*N-1:0] w_vec_in;
    logic [WIDTH*N-1:0] w_vec_out;
    logic [WIDTH-1:0]   w_perm [N];
    logic               w_wr_fire;
    logic               w_wr_wrap;
    logic               w_rd_fire;
    logic               w_rd_wrap;

    always_comb begin
        w_vec_in = '0;
        for (int i = 0; i < N; i++) begin
            w_vec_in[i*WIDTH +: WIDTH] = r_bank[r_rd_bank][i];
        end
    end

    vec_bit_reversal #(
        .WIDTH   (WIDTH)
    ) u_vec_bit_reversal (
        .vec_in  (w_vec_in),
        .vec_out (w_vec_out)
    );

    always_comb begin
        for (int i = 0; i < N; i++) begin
            w_perm[i] = w_vec_out[i*WIDTH +: WIDTH];
        end
    end

    // All outputs decode registered state only; no input reaches an output.
    assign in_ready    = !r_bank_full[r_wr_bank];
    assign out_valid   = r_bank_full[r_rd_bank];
    assign out_data    = w_perm[r_rd_idx];
    assign out_last    = out_valid && (r_rd_idx == LOG2N'(N-1));
    assign frames_done = r_frames_done;

    assign w_wr_fire = in_valid && in_ready;
    assign w_wr_wrap = w_wr_fire && (r_wr_idx == LOG2N'(N-1));
    assign w_rd_fire = out_valid && out_ready;
    assign w_rd_wrap = w_rd_fire && (r_rd_idx == LOG2N'(N-1));

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < N; i++) begin
                    r_bank[b][i] <= '0;
                end
            end
            r_bank_full   <= '0;
            r_wr_bank     <= 1'b0;
            r_wr_idx      <= '0;
            r_rd_bank     <= 1'b0;
            r_rd_idx      <= '0;
            r_frames_done <= '0;
        end else begin
            if (w_wr_fire) begin
                r_bank[r_wr_bank][r_wr_idx] <= in_data;
                r_wr_idx                    <= r_wr_idx + 1'b1;
                if (w_wr_wrap) begin
                    r_wr_bank <= ~r_wr_bank;
                end
            end
            if (w_rd_fire) begin
                r_rd_idx <= r_rd_idx + 1'b1;
                if (w_rd_wrap) begin
                    r_rd_bank     <= ~r_rd_bank;
                    r_frames_done <= r_frames_done + 16'd1;
                end
            end
            // A bank is only ever the write target while empty and the read
            // target while full, so set and clear never collide on one bank.
            for (int b = 0; b < 2; b++) begin
                if (w_wr_wrap && (r_wr_bank == 1'(b))) begin
                    r_bank_full[b] <= 1'b1;
                end
                if (w_rd_wrap && (r_rd_bank == 1'(b))) begin
                    r_bank_full[b] <= 1'b0;
                end
            end
        end
    end

endmodule

`default_nettype wire
